// File: rtl/morse_decoder.sv
// Morse symbol-code to ASCII translator feeding a valid/ready character FIFO.
// Optional word-gap space insertion is compiled in with `define MORSE_WORD_GAP_EN.
//
// gap FSM (MORSE_WORD_GAP_EN only)
//   state   | meaning
//   G_IDLE  | no letter since last space/keying, nothing pending
//   G_ARMED | letter queued, counting code_ready-high cycles toward a space
module morse_decoder #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  UNK_CHAR   = 8'h3F,
    parameter int          WORD_GAP   = 16000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       err_unknown,
    output logic       err_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic             ready_q;
    logic             cap_v;
    logic [7:0]       code_q;
    logic             dec_wr;
    logic             dec_unk;
    logic [7:0]       dec_char;
    logic [7:0]       lut_char;
    logic             lut_hit;
    logic             space_wr;
    logic             wr_req;
    logic [7:0]       wr_data;
    logic             pop;
    logic             full;
    logic             do_wr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];

    always_comb begin
        lut_hit  = 1'b1;
        lut_char = UNK_CHAR;
        case (code_q)
            8'h06: lut_char = 8'h41;
            8'h95: lut_char = 8'h42;
            8'h99: lut_char = 8'h43;
            8'h25: lut_char = 8'h44;
            8'h01: lut_char = 8'h45;
            8'h59: lut_char = 8'h46;
            8'h29: lut_char = 8'h47;
            8'h55: lut_char = 8'h48;
            8'h05: lut_char = 8'h49;
            8'h6A: lut_char = 8'h4A;
            8'h26: lut_char = 8'h4B;
            8'h65: lut_char = 8'h4C;
            8'h0A: lut_char = 8'h4D;
            8'h09: lut_char = 8'h4E;
            8'h2A: lut_char = 8'h4F;
            8'h69: lut_char = 8'h50;
            8'hA6: lut_char = 8'h51;
            8'h19: lut_char = 8'h52;
            8'h15: lut_char = 8'h53;
            8'h02: lut_char = 8'h54;
            8'h16: lut_char = 8'h55;
            8'h56: lut_char = 8'h56;
            8'h1A: lut_char = 8'h57;
            8'h96: lut_char = 8'h58;
            8'h9A: lut_char = 8'h59;
            8'hA5: lut_char = 8'h5A;
            default: lut_hit = 1'b0;
        endcase
    end

    // ready_q resets high so the idle-high code_ready is not seen as a new code
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= 1'b1;
            cap_v    <= 1'b0;
            code_q   <= 8'h00;
            dec_wr   <= 1'b0;
            dec_unk  <= 1'b0;
            dec_char <= 8'h00;
        end else begin
            ready_q  <= code_ready;
            cap_v    <= code_ready & ~ready_q;
            if (code_ready & ~ready_q)
                code_q <= code_in;
            dec_wr   <= cap_v && (code_q != 8'h00);
            dec_unk  <= ~lut_hit;
            dec_char <= lut_char;
        end
    end

`ifdef MORSE_WORD_GAP_EN
    typedef enum logic {G_IDLE, G_ARMED} gap_t;
    localparam logic [15:0] GAP_LAST = 16'(WORD_GAP - 1);

    gap_t        gap_state;
    gap_t        gap_next;
    logic [15:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_state <= G_IDLE;
            gap_cnt   <= 16'h0000;
        end else begin
            gap_state <= gap_next;
            if (dec_wr || gap_state == G_IDLE || !code_ready)
                gap_cnt <= 16'h0000;
            else
                gap_cnt <= gap_cnt + 16'h0001;
        end
    end

    always_comb begin
        gap_next = gap_state;
        if (dec_wr)
            gap_next = G_ARMED;
        else if (gap_state == G_ARMED && (!code_ready || gap_cnt == GAP_LAST))
            gap_next = G_IDLE;
    end

    always_comb begin
        space_wr = (gap_state == G_ARMED) && !dec_wr && code_ready && (gap_cnt == GAP_LAST);
    end
`else
    // word-gap spaces compiled out; the term is constant false
    assign space_wr = (WORD_GAP < 0);
`endif

    assign wr_req     = dec_wr | space_wr;
    assign wr_data    = dec_wr ? dec_char : 8'h20;
    assign char_valid = (wr_ptr != rd_ptr);
    assign char_data  = mem[rd_ptr[AW-1:0]];
    assign pop        = char_valid & char_ready;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr      = wr_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            err_unknown  <= 1'b0;
            err_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 8'h00;
        end else begin
            err_unknown  <= dec_wr & dec_unk;
            err_overflow <= wr_req & full & ~pop;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the character stream.
module tb_morse_decoder;
    localparam int DEPTH = 8;
`ifdef MORSE_WORD_GAP_EN
    localparam int GAP = 100;
`else
    localparam int GAP = 16000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic       code_ready;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       err_unknown;
    logic       err_overflow;

    always #5 clk = ~clk;

    morse_decoder #(.FIFO_DEPTH(DEPTH), .UNK_CHAR(8'h3F), .WORD_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_ready(code_ready),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .err_unknown(err_unknown), .err_overflow(err_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ovf_seen = 0;
    int unk_seen = 0;
    int spaces_seen = 0;

    // model: expected FIFO contents plus writes scheduled two edges after a new code
    logic [7:0] mq[$];
    logic       prev_ready;
    logic       pend_v [4];
    logic [7:0] pend_c [4];
    logic       pend_u [4];
    logic       exp_unk;
    logic       exp_ovf;
    bit         armed;
    int         idle_run;

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    function automatic logic [7:0] code_of(input int idx);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < morse[idx].len(); j++)
            c = {c[5:0], (morse[idx][j] == 8'h2E) ? 2'b01 : 2'b10};
        return c;
    endfunction

    function automatic logic [8:0] lookup(input logic [7:0] code);
        for (int i = 0; i < 26; i++)
            if (code_of(i) == code)
                return {1'b0, 8'(8'h41 + i)};
        return {1'b1, 8'h3F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int         slot;
        int         s2;
        bit         pop;
        bit         wr;
        bit         letter;
        logic [7:0] wc;
        logic [8:0] r;
        slot = cyc % 4;
        cyc++;
        exp_unk = 1'b0;
        exp_ovf = 1'b0;
        wr = 0;
        wc = 8'h00;
        if (rst) begin
            mq.delete();
            prev_ready = 1'b1;
            for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
            armed = 0;
            idle_run = 0;
            return;
        end
        pop = (mq.size() != 0) && char_ready;
        letter = pend_v[slot];
        if (letter) begin
            wr = 1;
            wc = pend_c[slot];
            exp_unk = pend_u[slot];
            pend_v[slot] = 1'b0;
        end
`ifdef MORSE_WORD_GAP_EN
        if (letter) begin
            armed = 1;
            idle_run = 0;
        end else if (armed) begin
            if (!code_ready) armed = 0;
            else begin
                idle_run++;
                if (idle_run == GAP) begin
                    wr = 1;
                    wc = 8'h20;
                    armed = 0;
                end
            end
        end
`endif
        if (pop) void'(mq.pop_front());
        if (wr) begin
            if (mq.size() < DEPTH) mq.push_back(wc);
            else exp_ovf = 1'b1;
        end
        if (code_ready && !prev_ready && code_in != 8'h00) begin
            r = lookup(code_in);
            s2 = (slot + 2) % 4;
            pend_v[s2] = 1'b1;
            pend_c[s2] = r[7:0];
            pend_u[s2] = r[8];
        end
        prev_ready = code_ready;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("char_valid", char_valid, (mq.size() != 0));
        if (mq.size() != 0) check("char_data", char_data, mq[0]);
        check("err_unknown", err_unknown, exp_unk);
        check("err_overflow", err_overflow, exp_ovf);
        if (err_overflow) ovf_seen++;
        if (err_unknown) unk_seen++;
        if (char_valid && char_ready && char_data == 8'h20) spaces_seen++;
    endtask

    task automatic send(input logic [7:0] code);
        code_in = code;
        code_ready = 1'b0;
        step();
        code_ready = 1'b1;
        step();
    endtask

    int base;

    initial begin
        rst = 1'b1;
        code_in = 8'h00;
        code_ready = 1'b1;
        char_ready = 1'b1;
        prev_ready = 1'b1;
        for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_data", char_data, 8'h00);
        check("reset_valid", char_valid, 1'b0);
        check("model_A_code", lookup(8'h06), {1'b0, 8'h41});
        check("model_Q_code", lookup(8'hA6), {1'b0, 8'h51});
        for (int i = 0; i < 50; i++) step();
        check("idle_no_valid", char_valid, 1'b0);
        check("idle_no_err", ovf_seen + unk_seen, 0);

        send(8'h06);
        step();
        step();
        check("A_valid", char_valid, 1'b1);
        check("A_data", char_data, 8'h41);
        step();
        check("A_one_cycle", char_valid, 1'b0);
        send(8'h55);
        step();
        step();
        check("H_data", char_data, 8'h48);

        send(8'h00);
        for (int i = 0; i < 4; i++) step();
        check("zero_nothing", char_valid, 1'b0);
        base = unk_seen;
        send(8'h07);
        step();
        step();
        check("unk_data", char_data, 8'h3F);
        check("unk_pulse", err_unknown, 1'b1);
        step();
        check("unk_once", unk_seen - base, 1);

        char_ready = 1'b0;
        base = ovf_seen;
        for (int i = 0; i < 9; i++) send(8'h01);
        step();
        step();
        check("ovf_once", ovf_seen - base, 1);
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", char_valid, 1'b1);
            check("drain_E", char_data, 8'h45);
            step();
        end
        check("drain_empty", char_valid, 1'b0);

        char_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h01);
        step();
        step();
        base = ovf_seen;
        send(8'h02);
        step();
        char_ready = 1'b1;
        step();
        char_ready = 1'b0;
        step();
        check("full_pop_no_ovf", ovf_seen - base, 0);
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("order_valid", char_valid, 1'b1);
            check("order_data", char_data, (i == 7) ? 8'h54 : 8'h45);
            step();
        end

        base = spaces_seen;
        send(8'h02);
        step();
        step();
        check("T_data", char_data, 8'h54);
`ifdef MORSE_WORD_GAP_EN
        for (int i = 0; i < GAP; i++) step();
        check("space_valid", char_valid, 1'b1);
        check("space_data", char_data, 8'h20);
        for (int i = 0; i < 60; i++) step();
        check("one_space", spaces_seen - base, 1);
        base = spaces_seen;
        send(8'h02);
        step();
        step();
        for (int i = 0; i < 49; i++) step();
        code_in = 8'h00;
        code_ready = 1'b0;
        step();
        code_ready = 1'b1;
        for (int i = 0; i < GAP + 20; i++) step();
        check("no_space_after_drop", spaces_seen - base, 0);
`else
        for (int i = 0; i < 150; i++) step();
        check("no_space_default", spaces_seen - base, 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            char_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) char_ready = 1'b0;
            rst = ($urandom_range(0, 599) == 0);
            if (code_ready && $urandom_range(0, 5) == 0) begin
                code_ready = 1'b0;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: code_in = code_of($urandom_range(0, 25));
                    6, 7: code_in = 8'($urandom);
                    default: code_in = 8'h00;
                endcase
            end else if (!code_ready && $urandom_range(0, 2) == 0) begin
                code_ready = 1'b1;
            end
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
